// File: rtl/enc_formatter.sv
// Input framer for enc_processor: buffers whole messages, then plays each out as HAL, FUL x FUL_NUM, PAR x RS_PAR_LEN.
// Define FOR_LAST_CHK_EN to check in_last framing on the write side (sticky for_err).
module enc_formatter #(
    parameter int RS_MES_LEN  = 239,
    parameter int RS_PAR_LEN  = 16,
    parameter int ENC_SYM_NUM = 16,
    parameter int EGF_ORDER   = 8,
    localparam int HLF_NUM    = RS_MES_LEN % ENC_SYM_NUM,
    localparam int HLF_W      = ((HLF_NUM > 0) ? HLF_NUM : 1) * EGF_ORDER,
    localparam int BEAT_W     = ENC_SYM_NUM * EGF_ORDER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [1:0]        for_phase,
    output logic [HLF_W-1:0]  for_half_data,
    output logic [BEAT_W-1:0] for_full_data,
    output logic              for_sof,
    output logic              for_eof,
    output logic              for_err
);

    localparam int FUL_NUM   = RS_MES_LEN / ENC_SYM_NUM;
    localparam int MES_BEATS = FUL_NUM + 1;
    localparam int BUF_DEPTH = 2 * MES_BEATS;
    localparam int CNT_MAX   = ((FUL_NUM > RS_PAR_LEN) ? FUL_NUM : RS_PAR_LEN) - 1;
    localparam int CNT_W     = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0] FUL_LAST = CNT_W'(FUL_NUM - 1);
    localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(RS_PAR_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_MES  = OCC_W'(MES_BEATS);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

    if (HLF_NUM == 0) begin : g_hlf_chk
        $error("enc_formatter: RS_MES_LEN must leave a non-empty half beat");
    end

    typedef enum logic [1:0] {
        FOR_IDL = 2'd0,
        FOR_HAL = 2'd1,
        FOR_FUL = 2'd2,
        FOR_PAR = 2'd3
    } for_phase_e;

    for_phase_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [HLF_W-1:0]  half_q, half_d;
    logic [BEAT_W-1:0] full_q, full_d;
    logic              sof_q, sof_d, eof_q, eof_d, err_q, err_d;
    logic              accept, pop, msg_rdy;

    assign in_ready = (occ_q < OCC_FULL);
    assign accept   = in_valid & in_ready;
    assign msg_rdy  = (occ_q >= OCC_MES);

    // NOTE: the beat store has no reset; pointers and occupancy alone say which entries are live.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= in_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FOR_IDL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output is defaulted first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FOR_IDL: if (msg_rdy) state_d = FOR_HAL;
            FOR_HAL: begin
                cnt_d   = '0;
                state_d = (FUL_NUM == 0) ? FOR_PAR : FOR_FUL;
            end
            FOR_FUL: begin
                if (cnt_q == FUL_LAST) begin
                    state_d = FOR_PAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FOR_PAR: begin
                if (cnt_q == PAR_LAST) begin
                    state_d = msg_rdy ? FOR_HAL : FOR_IDL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = FOR_IDL;
        endcase
    end

    // Outputs are computed for the phase being entered so phase and data move on the same edge.
    always_comb begin
        pop    = (state_d == FOR_HAL) || (state_d == FOR_FUL);
        half_d = '0;
        full_d = '0;
        if (state_d == FOR_HAL) half_d = mem[rd_ptr_q][HLF_W-1:0];
        if (state_d == FOR_FUL) full_d = mem[rd_ptr_q];
        sof_d    = (state_d == FOR_HAL);
        eof_d    = (state_d == FOR_PAR) && (cnt_d == PAR_LAST);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop)    rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        if (accept) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        occ_d = occ_q + OCC_W'(accept) - OCC_W'(pop);
    end

`ifdef FOR_LAST_CHK_EN
    localparam int WB_W = (MES_BEATS > 1) ? $clog2(MES_BEATS) : 1;
    localparam logic [WB_W-1:0] WB_LAST = WB_W'(MES_BEATS - 1);

    logic [WB_W-1:0] wbeat_q, wbeat_d;
    logic            beat_final;

    // in_last must coincide exactly with the final beat; any in_last restarts the beat count.
    always_comb begin
        beat_final = (wbeat_q == WB_LAST);
        err_d      = err_q | (accept & (in_last ^ beat_final));
        wbeat_d    = wbeat_q;
        if (accept) wbeat_d = (in_last | beat_final) ? '0 : wbeat_q + WB_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wbeat_q <= '0;
        else     wbeat_q <= wbeat_d;
    end
`else
    logic unused_last;
    assign unused_last = in_last;
    assign err_d       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            half_q   <= '0;
            full_q   <= '0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            half_q   <= half_d;
            full_q   <= full_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            err_q    <= err_d;
        end
    end

    assign for_phase     = state_q;
    assign for_half_data = half_q;
    assign for_full_data = full_q;
    assign for_sof       = sof_q;
    assign for_eof       = eof_q;
    assign for_err       = err_q;

endmodule

// File: tb/tb_enc_formatter.sv
// Self-checking bench for enc_formatter: queue-based message model compared every cycle, plus pinned literals.
module tb_enc_formatter;

    localparam int RS_MES_LEN  = 239;
    localparam int RS_PAR_LEN  = 16;
    localparam int ENC_SYM_NUM = 16;
    localparam int EGF_ORDER   = 8;
    localparam int BEAT_W      = 128;
    localparam int HLF_W       = 120;
    localparam int FUL_NUM     = 14;
    localparam int MES_BEATS   = 15;
    localparam int BUF_DEPTH   = 30;
    localparam logic [1:0] P_IDL = 2'd0, P_HAL = 2'd1, P_FUL = 2'd2, P_PAR = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BEAT_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [1:0]        for_phase;
    logic [HLF_W-1:0]  for_half_data;
    logic [BEAT_W-1:0] for_full_data;
    logic              for_sof, for_eof, for_err;

    enc_formatter #(
        .RS_MES_LEN (RS_MES_LEN),
        .RS_PAR_LEN (RS_PAR_LEN),
        .ENC_SYM_NUM(ENC_SYM_NUM),
        .EGF_ORDER  (EGF_ORDER)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .for_phase    (for_phase),
        .for_half_data(for_half_data),
        .for_full_data(for_full_data),
        .for_sof      (for_sof),
        .for_eof      (for_eof),
        .for_err      (for_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [BEAT_W-1:0] got, input logic [BEAT_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: buffered beats, plus the phase list of the message currently playing out.
    logic [BEAT_W-1:0] mq[$];
    logic [1:0]        sched[$];
    logic [1:0]        e_phase = P_IDL;
    logic [HLF_W-1:0]  e_half = '0;
    logic [BEAT_W-1:0] e_full = '0;
    bit                e_sof, e_eof, e_err, e_ready = 1'b1, acc_flag;
    int                widx = 0;

    task automatic model_reset();
        mq.delete();
        sched.delete();
        e_phase = P_IDL; e_half = '0; e_full = '0;
        e_sof = 0; e_eof = 0; e_err = 0; e_ready = 1; acc_flag = 0;
        widx = 0;
    endtask

    task automatic model_step();
        bit acc;
        logic [BEAT_W-1:0] b;
        acc = in_valid && (mq.size() < BUF_DEPTH);
        if (sched.size() == 0 && mq.size() >= MES_BEATS) begin
            sched.push_back(P_HAL);
            for (int i = 0; i < FUL_NUM; i++) sched.push_back(P_FUL);
            for (int i = 0; i < RS_PAR_LEN; i++) sched.push_back(P_PAR);
        end
        e_phase = P_IDL; e_half = '0; e_full = '0; e_sof = 0; e_eof = 0;
        if (sched.size() > 0) begin
            e_phase = sched.pop_front();
            if (e_phase == P_HAL) begin
                b = mq.pop_front();
                e_half = b[HLF_W-1:0];
                e_sof = 1;
            end else if (e_phase == P_FUL) begin
                e_full = mq.pop_front();
            end else begin
                e_eof = (sched.size() == 0);
            end
        end
        acc_flag = acc;
        if (acc) begin
            mq.push_back(in_data);
`ifdef FOR_LAST_CHK_EN
            if (in_last != (widx == MES_BEATS - 1)) e_err = 1;
            widx = (in_last || widx == MES_BEATS - 1) ? 0 : widx + 1;
`endif
        end
        e_ready = (mq.size() < BUF_DEPTH);
    endtask

    int cyc = 0;
    int acc_total = 0;
    int last_acc_cyc = 0;
    int sof_cyc[$];
    int eof_cyc[$];
    bit seen_full = 0;

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
        #1;
        cyc++;
        if (acc_flag) begin
            acc_total++;
            last_acc_cyc = cyc;
        end
        check("phase",     BEAT_W'(for_phase),     BEAT_W'(e_phase));
        check("half_data", BEAT_W'(for_half_data), BEAT_W'(e_half));
        check("full_data", for_full_data,          e_full);
        check("sof",       BEAT_W'(for_sof),       BEAT_W'(e_sof));
        check("eof",       BEAT_W'(for_eof),       BEAT_W'(e_eof));
        check("err",       BEAT_W'(for_err),       BEAT_W'(e_err));
        check("in_ready",  BEAT_W'(in_ready),      BEAT_W'(e_ready));
        if (for_sof) sof_cyc.push_back(cyc);
        if (for_eof) eof_cyc.push_back(cyc);
        if (!in_ready) seen_full = 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic send_beat(input logic [BEAT_W-1:0] d, input bit last);
        int waited;
        bit ok;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last;
        ok = in_ready;
        @(posedge clk);
        while (!ok && waited < 500) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            waited++;
        end
        if (!ok) check("accept_wait", BEAT_W'(ok), BEAT_W'(1));
    endtask

    function automatic logic [BEAT_W-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_msg(input int max_gap, input int last_idx, output logic [BEAT_W-1:0] first);
        logic [BEAT_W-1:0] d;
        first = '0;
        for (int i = 0; i < MES_BEATS; i++) begin
            d = rand_beat();
            if (i == 0) first = d;
            send_beat(d, i == last_idx);
            if (max_gap > 0 && i < MES_BEATS - 1) idle($urandom_range(max_gap, 1));
        end
    endtask

    task automatic clear_logs();
        sof_cyc.delete();
        eof_cyc.delete();
    endtask

    task automatic wait_eofs(input int n, input int budget);
        int k;
        k = 0;
        while (eof_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("eof_count", BEAT_W'(eof_cyc.size()), BEAT_W'(n));
    endtask

    // Send one message, then pin the HAL cycle by hand: still IDL after the last accept, HAL on the next edge.
    task automatic msg_and_pin_hal(input int max_gap, input string tag);
        logic [BEAT_W-1:0] first;
        send_msg(max_gap, MES_BEATS - 1, first);
        idle(1);
        check({tag, "_idle_before_hal"}, BEAT_W'(for_phase), BEAT_W'(P_IDL));
        @(posedge clk);
        #2;
        check({tag, "_hal_phase"}, BEAT_W'(for_phase), BEAT_W'(P_HAL));
        check({tag, "_hal_half"},  BEAT_W'(for_half_data), BEAT_W'(first[HLF_W-1:0]));
        check({tag, "_hal_sof"},   BEAT_W'(for_sof), BEAT_W'(1));
        check({tag, "_hal_latency"}, BEAT_W'(cyc - last_acc_cyc), BEAT_W'(1));
        wait_eofs(1, 100);
        idle(3);
        check({tag, "_back_idle"}, BEAT_W'(for_phase), BEAT_W'(P_IDL));
        check({tag, "_sof_once"},  BEAT_W'(sof_cyc.size()), BEAT_W'(1));
        if (sof_cyc.size() == 1 && eof_cyc.size() == 1)
            check({tag, "_run_len"}, BEAT_W'(eof_cyc[0] - sof_cyc[0]), BEAT_W'(FUL_NUM + RS_PAR_LEN));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BEAT_W-1:0] dummy;
        int acc0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_phase", BEAT_W'(for_phase), BEAT_W'(P_IDL));
        check("rst_ready", BEAT_W'(in_ready), BEAT_W'(1));
        check("rst_full",  for_full_data, '0);
        rst = 1'b0;
        idle(2);

        // Single message at one beat per cycle, then a gapped one
        clear_logs();
        msg_and_pin_hal(0, "single");
        clear_logs();
        msg_and_pin_hal(2, "gapped");

        // Three messages back-to-back: one continuous 93-cycle run
        clear_logs();
        for (int m = 0; m < 3; m++) send_msg(0, MES_BEATS - 1, dummy);
        idle(1);
        wait_eofs(3, 200);
        check("b2b_sof_count", BEAT_W'(sof_cyc.size()), BEAT_W'(3));
        if (sof_cyc.size() == 3 && eof_cyc.size() == 3)
            check("b2b_no_gap", BEAT_W'(eof_cyc[2] - sof_cyc[0]), BEAT_W'(3 * (MES_BEATS + RS_PAR_LEN) - 1));

        // Backpressure: six messages with in_valid held high fills the buffer
        clear_logs();
        seen_full = 0;
        acc0 = acc_total;
        for (int m = 0; m < 6; m++) send_msg(0, MES_BEATS - 1, dummy);
        idle(1);
        wait_eofs(6, 400);
        check("bp_saw_full", BEAT_W'(seen_full), BEAT_W'(1));
        check("bp_accepts",  BEAT_W'(acc_total - acc0), BEAT_W'(6 * MES_BEATS));
        check("bp_err_clear", BEAT_W'(for_err), BEAT_W'(0));

        // Random gaps
        clear_logs();
        for (int m = 0; m < 4; m++) send_msg($urandom_range(3, 0), MES_BEATS - 1, dummy);
        idle(1);
        wait_eofs(4, 400);

        // Framing: in_last on beat 13
        clear_logs();
        send_msg(0, MES_BEATS - 2, dummy);
        idle(1);
        wait_eofs(1, 100);
        idle(3);
`ifdef FOR_LAST_CHK_EN
        check("frame_err_set", BEAT_W'(for_err), BEAT_W'(1));
`else
        check("frame_err_off", BEAT_W'(for_err), BEAT_W'(0));
`endif
        check("frame_sof_count", BEAT_W'(sof_cyc.size()), BEAT_W'(1));

        // Asynchronous reset in the middle of FUL
        clear_logs();
        send_msg(0, MES_BEATS - 1, dummy);
        idle(1);
        begin
            int k;
            k = 0;
            while (for_phase != P_FUL && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        check("reach_ful", BEAT_W'(for_phase), BEAT_W'(P_FUL));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_phase", BEAT_W'(for_phase), BEAT_W'(P_IDL));
        check("arst_ready", BEAT_W'(in_ready), BEAT_W'(1));
        check("arst_full",  for_full_data, '0);
        check("arst_half",  BEAT_W'(for_half_data), '0);
        check("arst_flags", BEAT_W'({for_sof, for_eof, for_err}), '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        clear_logs();
        msg_and_pin_hal(0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
